// File: rtl/pdp8_pkg.sv
// Shared PDP-8 widths, decoded-opcode structs and the execute-FSM state enum.
package pdp8_pkg;

  localparam int ADDR_WIDTH = 12;
  localparam int DATA_WIDTH = 12;

  typedef struct packed {
    logic                  op_and;
    logic                  op_tad;
    logic                  op_isz;
    logic                  op_dca;
    logic                  op_jms;
    logic                  op_jmp;
    logic                  op_nop;
    logic [ADDR_WIDTH-1:0] mem_inst_addr;
  } pdp_mem_opcode_s;

  // Group-1 bits, then group-2 bits, then HLT/OSR/NOP.
  typedef struct packed {
    logic cla1;
    logic cll;
    logic cma;
    logic cml;
    logic iac;
    logic rar;
    logic ral;
    logic rtr;
    logic rtl;
    logic cla2;
    logic sma;
    logic sza;
    logic snl;
    logic spa;
    logic sna;
    logic szl;
    logic skp;
    logic osr;
    logic hlt;
    logic nop;
  } pdp_op7_opcode_s;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_RD_WAIT, S_EXEC, S_WB, S_DONE, S_HALT
  } exec_state_e;

  function automatic logic mem_any(input pdp_mem_opcode_s m);
    return m.op_and | m.op_tad | m.op_isz | m.op_dca | m.op_jms | m.op_jmp | m.op_nop;
  endfunction

  function automatic logic op7_any(input pdp_op7_opcode_s o);
    return |o;
  endfunction

endpackage

// File: rtl/instr_exec_op7.sv
// Combinational operate-group microcode: group-1 AC/L transforms, group-2 skip test.
module op7_alu
  import pdp8_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] ac,
  input  logic                  l,
  input  pdp_op7_opcode_s       op,
  output logic [DATA_WIDTH-1:0] ac_nxt,
  output logic                  l_nxt,
  output logic                  skip
);
  logic [DATA_WIDTH:0] v;
  logic neg, zero, rev, or_skip, and_skip;
  logic unused_flags;

  assign unused_flags = op.osr ^ op.nop ^ op.hlt;

  // {L,AC} is treated as one 13-bit value so IAC carry and rotates fall out naturally.
  always_comb begin
    v = {l, ac};
    if (op.cla1) v[DATA_WIDTH-1:0] = '0;
    if (op.cll)  v[DATA_WIDTH] = 1'b0;
    if (op.cma)  v[DATA_WIDTH-1:0] = ~v[DATA_WIDTH-1:0];
    if (op.cml)  v[DATA_WIDTH] = ~v[DATA_WIDTH];
    if (op.iac)  v = v + 1'b1;
    if (op.rar)      v = {v[0], v[DATA_WIDTH:1]};
    else if (op.ral) v = {v[DATA_WIDTH-1:0], v[DATA_WIDTH]};
    else if (op.rtr) v = {v[1:0], v[DATA_WIDTH:2]};
    else if (op.rtl) v = {v[DATA_WIDTH-2:0], v[DATA_WIDTH:DATA_WIDTH-1]};
  end

  assign neg      = v[DATA_WIDTH-1];
  assign zero     = (v[DATA_WIDTH-1:0] == '0);
  assign rev      = op.spa | op.sna | op.szl;
  assign or_skip  = (op.sma & neg) | (op.sza & zero) | (op.snl & v[DATA_WIDTH]);
  assign and_skip = (~op.spa | ~neg) & (~op.sna | ~zero) & (~op.szl | ~v[DATA_WIDTH]);
  assign skip     = op.skp | (rev ? and_skip : or_skip);
  assign ac_nxt   = op.cla2 ? '0 : v[DATA_WIDTH-1:0];
  assign l_nxt    = v[DATA_WIDTH];

endmodule

// File: rtl/instr_exec.sv
// PDP-8 execute unit: sequences memory-reference and operate instructions, owns PC/AC/L.
module instr_exec
  import pdp8_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  pdp_mem_opcode_s       pdp_mem_opcode,
  input  pdp_op7_opcode_s       pdp_op7_opcode,
  output logic                  stall,
  output logic [ADDR_WIDTH-1:0] PC_value,
  output logic                  exec_rd_req,
  output logic [ADDR_WIDTH-1:0] exec_rd_addr,
  input  logic [DATA_WIDTH-1:0] exec_rd_data,
  output logic                  exec_wr_req,
  output logic [ADDR_WIDTH-1:0] exec_wr_addr,
  output logic [DATA_WIDTH-1:0] exec_wr_data,
  output logic [DATA_WIDTH-1:0] ac_out,
  output logic                  link_out,
  output logic                  halted
);
  exec_state_e           state, state_nxt;
  pdp_mem_opcode_s       cur_mem;
  pdp_op7_opcode_s       cur_op7;
  logic [ADDR_WIDTH-1:0] pc, ea;
  logic [DATA_WIDTH-1:0] ac, mdata, alu_ac;
  logic                  l, alu_l, alu_skip, accept, new_mem;

  assign ea      = cur_mem.mem_inst_addr;
  assign new_mem = mem_any(pdp_mem_opcode);
  assign accept  = (state == S_IDLE) && (new_mem || op7_any(pdp_op7_opcode));

  op7_alu u_op7_alu (
    .ac(ac), .l(l), .op(cur_op7), .ac_nxt(alu_ac), .l_nxt(alu_l), .skip(alu_skip)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Request pulses are gated by reset_n so an abandoned instruction never touches memory.
  always_comb begin
    state_nxt    = state;
    exec_rd_req  = 1'b0;
    exec_wr_req  = 1'b0;
    exec_wr_data = ac;
    case (state)
      S_IDLE: if (accept) begin
        if (new_mem) begin
          if (pdp_mem_opcode.op_and | pdp_mem_opcode.op_tad | pdp_mem_opcode.op_isz)
            state_nxt = S_RD;
          else if (pdp_mem_opcode.op_dca | pdp_mem_opcode.op_jms)
            state_nxt = S_WB;
          else
            state_nxt = S_EXEC;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_RD: begin
        exec_rd_req = reset_n;
        state_nxt   = S_RD_WAIT;
      end
      S_RD_WAIT: state_nxt = S_EXEC;
      S_EXEC: begin
        if (cur_mem.op_isz)   state_nxt = S_WB;
        else if (cur_op7.hlt) state_nxt = S_HALT;
        else                  state_nxt = S_DONE;
      end
      S_WB: begin
        exec_wr_req = reset_n;
        if (cur_mem.op_isz)      exec_wr_data = mdata;
        else if (cur_mem.op_jms) exec_wr_data = pc + 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // PC is settled on entry to DONE so it is stable for the whole DONE cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc      <= base_addr;
      ac      <= '0;
      l       <= 1'b0;
      mdata   <= '0;
      cur_mem <= '0;
      cur_op7 <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          cur_mem <= pdp_mem_opcode;
          cur_op7 <= new_mem ? '0 : pdp_op7_opcode;
        end
        S_RD_WAIT: mdata <= exec_rd_data;
        S_EXEC: begin
          if (cur_mem.op_and) begin
            ac <= ac & mdata;
            pc <= pc + 1'b1;
          end else if (cur_mem.op_tad) begin
            {l, ac} <= {l, ac} + {1'b0, mdata};
            pc      <= pc + 1'b1;
          end else if (cur_mem.op_isz) begin
            mdata <= mdata + 1'b1;
          end else if (cur_mem.op_jmp) begin
            pc <= ea;
          end else if (cur_mem.op_nop) begin
            pc <= pc + 1'b1;
          end else begin
            ac <= alu_ac;
            l  <= alu_l;
            if (!cur_op7.hlt) pc <= pc + (alu_skip ? ADDR_WIDTH'(2) : ADDR_WIDTH'(1));
          end
        end
        S_WB: begin
          if (cur_mem.op_isz) begin
            pc <= pc + ((mdata == '0) ? ADDR_WIDTH'(2) : ADDR_WIDTH'(1));
          end else if (cur_mem.op_dca) begin
            ac <= '0;
            pc <= pc + 1'b1;
          end else begin
            pc <= ea + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign stall        = (state != S_IDLE);
  assign halted       = (state == S_HALT);
  assign PC_value     = pc;
  assign ac_out       = ac;
  assign link_out     = l;
  assign exec_rd_addr = ea;
  assign exec_wr_addr = ea;

endmodule

// File: tb/tb_instr_exec.sv
// Randomized self-checking bench for instr_exec against an arithmetic PDP-8 reference model.
module tb_instr_exec;
  import pdp8_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic [ADDR_WIDTH-1:0] base_addr = 12'o200;
  pdp_mem_opcode_s       mem_op = '0;
  pdp_op7_opcode_s       op7_op = '0;
  logic                  stall, exec_rd_req, exec_wr_req, link_out, halted;
  logic [ADDR_WIDTH-1:0] pc_value, exec_rd_addr, exec_wr_addr;
  logic [DATA_WIDTH-1:0] exec_rd_data = '0;
  logic [DATA_WIDTH-1:0] exec_wr_data, ac_out;

  logic [DATA_WIDTH-1:0] mem [4096];
  int rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
  int last_rd_addr = 0, last_wr_addr = 0, last_wr_data = 0;
  int n_chk = 0, n_pass = 0;
  int m_pc, m_ac, m_l;

  always #5 clk = ~clk;

  instr_exec dut (
    .clk(clk), .reset_n(reset_n), .base_addr(base_addr),
    .pdp_mem_opcode(mem_op), .pdp_op7_opcode(op7_op),
    .stall(stall), .PC_value(pc_value),
    .exec_rd_req(exec_rd_req), .exec_rd_addr(exec_rd_addr), .exec_rd_data(exec_rd_data),
    .exec_wr_req(exec_wr_req), .exec_wr_addr(exec_wr_addr), .exec_wr_data(exec_wr_data),
    .ac_out(ac_out), .link_out(link_out), .halted(halted)
  );

  // Memory model: read data presented from mid-request-cycle through the following cycle.
  always @(negedge clk) begin
    if (exec_rd_req) begin
      rd_cnt++;
      last_rd_addr = int'(exec_rd_addr);
      exec_rd_data = mem[exec_rd_addr];
    end
    if (exec_wr_req) begin
      wr_cnt++;
      last_wr_addr = int'(exec_wr_addr);
      last_wr_data = int'(exec_wr_data);
      mem[exec_wr_addr] = exec_wr_data;
    end
    if (exec_rd_req && exec_wr_req) both_cnt++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0o expected %0o", tag, got, exp);
  endtask

  task automatic op7_model(input pdp_op7_opcode_s o, input int ac, input int l,
                           output int ac_n, output int l_n, output int skip);
    int v, a, lk;
    bit neg;
    v = l * 4096 + ac;
    if (o.cla1) v = (v / 4096) * 4096;
    if (o.cll)  v = v % 4096;
    if (o.cma)  v = (v / 4096) * 4096 + (4095 - v % 4096);
    if (o.cml)  v = v ^ 4096;
    if (o.iac)  v = (v + 1) % 8192;
    if (o.rar)  v = v / 2 + (v % 2) * 4096;
    if (o.ral)  v = (v * 2) % 8192 + v / 4096;
    if (o.rtr)  repeat (2) v = v / 2 + (v % 2) * 4096;
    if (o.rtl)  repeat (2) v = (v * 2) % 8192 + v / 4096;
    a = v % 4096;
    lk = v / 4096;
    neg = (a >= 2048);
    if (o.spa || o.sna || o.szl)
      skip = int'((!o.spa || !neg) && (!o.sna || a != 0) && (!o.szl || lk == 0));
    else
      skip = int'((o.sma && neg) || (o.sza && a == 0) || (o.snl && lk == 1));
    if (o.skp) skip = 1;
    ac_n = o.cla2 ? 0 : a;
    l_n = lk;
  endtask

  task automatic issue(input pdp_mem_opcode_s m, input pdp_op7_opcode_s o, output int cyc);
    @(negedge clk);
    mem_op = m;
    op7_op = o;
    @(negedge clk);
    mem_op = '0;
    op7_op = '0;
    cyc = 0;
    while (stall && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  // kind: 0 AND 1 TAD 2 ISZ 3 DCA 4 JMS 5 JMP 6 NOP 7 op7 group 1 8 op7 group 2
  task automatic run(input int kind, input int ea, input pdp_op7_opcode_s o);
    pdp_mem_opcode_s m;
    int mv, s, e_pc, e_ac, e_l, e_rd, e_wr, e_wd, e_cyc, skip, cyc, rd0, wr0;
    m = '0;
    m.mem_inst_addr = 12'(ea);
    mv = int'(mem[ea]);
    e_pc = (m_pc + 1) % 4096; e_ac = m_ac; e_l = m_l;
    e_rd = 0; e_wr = 0; e_wd = 0; e_cyc = 2; skip = 0;
    case (kind)
      0: begin m.op_and = 1'b1; e_ac = m_ac & mv; e_rd = 1; e_cyc = 4; end
      1: begin
        m.op_tad = 1'b1; s = m_l * 4096 + m_ac + mv;
        e_ac = s % 4096; e_l = (s / 4096) % 2; e_rd = 1; e_cyc = 4;
      end
      2: begin
        m.op_isz = 1'b1; e_wd = (mv + 1) % 4096; e_rd = 1; e_wr = 1; e_cyc = 5;
        if (e_wd == 0) e_pc = (m_pc + 2) % 4096;
      end
      3: begin m.op_dca = 1'b1; e_wr = 1; e_wd = m_ac; e_ac = 0; end
      4: begin m.op_jms = 1'b1; e_wr = 1; e_wd = (m_pc + 1) % 4096; e_pc = (ea + 1) % 4096; end
      5: begin m.op_jmp = 1'b1; e_pc = ea; end
      6: m.op_nop = 1'b1;
      default: begin
        op7_model(o, m_ac, m_l, e_ac, e_l, skip);
        e_pc = (m_pc + 1 + skip) % 4096;
      end
    endcase
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    issue(m, o, cyc);
    chk($sformatf("k%0d pc", kind), int'(pc_value), e_pc);
    chk($sformatf("k%0d ac", kind), int'(ac_out), e_ac);
    chk($sformatf("k%0d link", kind), int'(link_out), e_l);
    chk($sformatf("k%0d stall cycles", kind), cyc, e_cyc);
    chk($sformatf("k%0d reads", kind), rd_cnt - rd0, e_rd);
    chk($sformatf("k%0d writes", kind), wr_cnt - wr0, e_wr);
    if (e_rd != 0) chk($sformatf("k%0d rd addr", kind), last_rd_addr, ea);
    if (e_wr != 0) begin
      chk($sformatf("k%0d wr addr", kind), last_wr_addr, ea);
      chk($sformatf("k%0d wr data", kind), last_wr_data, e_wd);
    end
    m_pc = e_pc; m_ac = e_ac; m_l = e_l;
  endtask

  function automatic pdp_op7_opcode_s rand_op7(input int grp);
    pdp_op7_opcode_s o;
    o = '0;
    if (grp == 1) begin
      o.cla1 = 1'($urandom_range(1)); o.cll = 1'($urandom_range(1));
      o.cma  = 1'($urandom_range(1)); o.cml = 1'($urandom_range(1));
      o.iac  = 1'($urandom_range(1));
      case ($urandom_range(4))
        1: o.rar = 1'b1;
        2: o.ral = 1'b1;
        3: o.rtr = 1'b1;
        4: o.rtl = 1'b1;
        default: ;
      endcase
    end else begin
      if ($urandom_range(1) == 1) begin
        o.spa = 1'($urandom_range(1)); o.sna = 1'($urandom_range(1)); o.szl = 1'($urandom_range(1));
      end else begin
        o.sma = 1'($urandom_range(1)); o.sza = 1'($urandom_range(1)); o.snl = 1'($urandom_range(1));
      end
      o.skp  = ($urandom_range(7) == 0);
      o.cla2 = 1'($urandom_range(1));
    end
    if (o == '0) o.nop = 1'b1;
    return o;
  endfunction

  initial begin
    pdp_op7_opcode_s o;
    pdp_mem_opcode_s m;
    int cyc, rd0, wr0, n, kind, ea;
    for (int i = 0; i < 4096; i++) mem[i] = 12'($urandom);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset pc", int'(pc_value), 'o200);
    chk("reset ac", int'(ac_out), 0);
    chk("reset link", int'(link_out), 0);
    chk("reset stall", int'(stall), 0);
    chk("reset halted", int'(halted), 0);
    chk("reset rd_req", int'(exec_rd_req), 0);
    chk("reset wr_req", int'(exec_wr_req), 0);
    m_pc = 'o200; m_ac = 0; m_l = 0;

    // Directed: AC=1 then TAD 7777 carries into L.
    o = '0; o.cla1 = 1'b1; o.cll = 1'b1; o.iac = 1'b1;
    run(7, 0, o);
    mem['o50] = 12'o7777;
    run(1, 'o50, '0);
    mem['o60] = 12'o7777;
    run(2, 'o60, '0);
    run(5, 'o200, '0);
    run(4, 'o300, '0);
    mem['o100] = 12'o1234;
    o = '0; o.cla1 = 1'b1;
    run(7, 0, o);
    run(1, 'o100, '0);
    run(3, 'o70, '0);
    o = '0; o.cla1 = 1'b1; o.cll = 1'b1; o.iac = 1'b1; o.ral = 1'b1;
    run(7, 0, o);
    o = '0; o.cla1 = 1'b1;
    run(7, 0, o);
    o = '0; o.sza = 1'b1;
    run(8, 0, o);
    o = '0; o.cla1 = 1'b1; o.cma = 1'b1;
    run(0, 'o20, o);

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(8);
      ea = $urandom_range(4095);
      if (kind == 2 && $urandom_range(2) == 0) mem[ea] = 12'o7777;
      if (kind >= 7)                    o = rand_op7(kind - 6);
      else if ($urandom_range(3) == 0)  o = rand_op7(1);
      else                              o = '0;
      run(kind, ea, o);
    end

    // Reset while an ISZ sits in RD_WAIT: no write may escape.
    m = '0; m.op_isz = 1'b1; m.mem_inst_addr = 12'o400;
    wr0 = wr_cnt;
    @(negedge clk); mem_op = m;
    @(negedge clk); mem_op = '0;
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    chk("mid-reset writes", wr_cnt - wr0, 0);
    chk("mid-reset pc", int'(pc_value), 'o200);
    chk("mid-reset stall", int'(stall), 0);
    chk("mid-reset ac", int'(ac_out), 0);
    m_pc = 'o200; m_ac = 0; m_l = 0;
    run(1, $urandom_range(4095), '0);
    run(4, $urandom_range(4095), '0);

    // HLT freezes the unit.
    o = '0; o.hlt = 1'b1;
    @(negedge clk); op7_op = o;
    @(negedge clk); op7_op = '0;
    cyc = 0;
    while (!halted && cyc < 10) begin
      cyc++;
      @(negedge clk);
    end
    chk("halted", int'(halted), 1);
    rd0 = rd_cnt; wr0 = wr_cnt; n = 0;
    m = '0; m.op_isz = 1'b1; m.mem_inst_addr = 12'o500;
    mem_op = m;
    repeat (6) begin
      @(negedge clk);
      if (stall && halted) n++;
    end
    mem_op = '0;
    chk("halt stall held", n, 6);
    chk("halt pc", int'(pc_value), m_pc);
    chk("halt reads", rd_cnt - rd0, 0);
    chk("halt writes", wr_cnt - wr0, 0);
    chk("rd and wr same cycle", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_exec.md
INSTR_EXEC -- requirements
Module: instr_exec

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: clk (clock) and reset_n (synchronous active-low reset).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 base_addr  input  `ADDR_WIDTH  program start address, loaded into PC at reset.
REQ-005 pdp_mem_opcode  input  pdp_mem_opcode_s  one-hot AND/TAD/ISZ/DCA/JMS/JMP/NOP flags plus resolved effective address mem_inst_addr, from instr_decode.
REQ-006 pdp_op7_opcode  input  pdp_op7_opcode_s  one-hot group-1/group-2 microinstruction flags, from instr_decode.
REQ-007 stall  output  1  high while an instruction is executing; instr_decode holds or advances only when low.
REQ-008 PC_value  output  `ADDR_WIDTH  current program counter, consumed by instr_decode.
REQ-009 exec_rd_req / exec_rd_addr  output  1 / `ADDR_WIDTH  operand read request, one-cycle pulse.
REQ-010 exec_rd_data  input  `DATA_WIDTH  read data, valid the cycle after exec_rd_req.
REQ-011 exec_wr_req / exec_wr_addr / exec_wr_data  output  1 / `ADDR_WIDTH / `DATA_WIDTH  one-cycle write pulse.
REQ-012 ac_out, link_out, halted  output  `DATA_WIDTH, 1, 1  architectural AC, L and halt status for checkers.

Function
REQ-013 Instruction accept: in IDLE with stall=0, any set opcode flag is latched with its EA; stall=1 from the next cycle.
REQ-014 FSM states: IDLE, RD, RD_WAIT, EXEC, WB, DONE, HALT.
REQ-015 AND/TAD/ISZ: IDLE->RD (exec_rd_req=1, addr=EA)->RD_WAIT (capture data)->EXEC->(ISZ only: WB)->DONE.
REQ-016 DCA: IDLE->WB (write AC to EA, AC=0)->DONE; JMS: IDLE->WB (write PC+1 to EA, PC=EA+1)->DONE; JMP: IDLE->EXEC (PC=EA)->DONE.
REQ-017 AND: AC=AC&M; TAD: {L,AC}={L,AC}+{0,M}, L toggled on carry out of bit 11; ISZ: M+1 mod 4096 written back, skip if result 0.
REQ-018 OP7 group 1, applied in order: CLA/CLL, then CMA/CML, then IAC (carry toggles L), then RAR/RAL/RTR/RTL over 13-bit {L,AC}.
REQ-019 OP7 group 2: skip if (SMA&AC[11])|(SZA&AC==0)|(SNL&L); reversed sense for SPA/SNA/SZL (AND of negated conditions); SKP unconditional; CLA applied after test; OSR treated as no-op.
REQ-020 HLT: enter HALT, stall and halted held 1, no further accepts until reset.
REQ-021 PC update in DONE: +1 default, +2 on skip, branch target for JMP/JMS; all PC arithmetic modulo 2^12.
REQ-022 DONE drops stall the following cycle and returns to IDLE; PC_value stable from DONE onward.
REQ-023 Both mem and op7 flags set: mem opcode takes priority; op7 flags ignored.
REQ-024 exec_rd_req and exec_wr_req never asserted in the same cycle; at most one pulse of each per instruction.

Reset
REQ-025 reset_n=0: PC=base_addr, AC=0, L=0, state=IDLE, stall=0, halted=0, all req outputs 0, next cycle.
REQ-026 Reset mid-instruction abandons it; no read or write pulse is issued in a cycle where reset_n=0.

Structure
REQ-027 `ADDR_WIDTH, `DATA_WIDTH, pdp_mem_opcode_s, pdp_op7_opcode_s and the new exec state enum live in pdp8_pkg.
REQ-028 Group-1/2 microcode evaluation SHALL be a combinational sub-module op7_alu (inputs AC, L, op7 flags; outputs AC', L', skip).

Verification
REQ-029 base_addr=0200 (octal), reset -> PC_value=0200, AC=0, stall=0.
REQ-030 TAD EA=0050, M[0050]=7777, AC=0001, L=0 -> one read at 0050, AC=0000, L=1, PC+1, stall high exactly 4 cycles.
REQ-031 ISZ EA=0060, M=7777 -> write 0000 to 0060, PC+2.
REQ-032 JMS EA=0300 at PC=0200 -> write 0201 to 0300, PC=0301; DCA EA=0070 with AC=1234 -> write 1234, AC=0.
REQ-033 OP7 CLA+IAC+RAL, L=0 -> AC=0002; SZA with AC=0 -> PC+2; HLT -> halted=1, stall stuck high.
REQ-034 Reset asserted in RD_WAIT of ISZ -> no write, PC=base_addr, normal fetch afterwards.
